// File: rtl/hw_win_pkg.sv
// hw_win_pkg -- shared constants and types for the sample windowing block.
//   FRAME_LEN : default samples per frame
//   SMP_W     : default signed sample width
//   COEF_W    : default unsigned window coefficient width
//   PROD_W    : windowed product width (SMP_W + COEF_W)
//   ADDR_W    : sample buffer / window ROM address width
//   state_t   : controller FSM states
package hw_win_pkg;

  localparam int FRAME_LEN = 80;
  localparam int SMP_W     = 16;
  localparam int COEF_W    = 4;
  localparam int PROD_W    = SMP_W + COEF_W;
  localparam int ADDR_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/hw_win_mac.sv
// hw_win_mac -- windowing multiply and output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : pipeline advance; output register loads only when high
//   bypass_i   : 1 = pass sample shifted left by COEF_W, coefficient ignored
//   valid_i    : stage-1 valid (memory outputs belong to an issued index)
//   smp_i      : signed sample from the synchronous-read sample buffer
//   coef_i     : unsigned coefficient from the registered window ROM
//   data_o     : signed windowed sample (SMP_W+COEF_W bits)
//   valid_o    : data_o valid
module hw_win_mac #(
  parameter int SMP_W  = hw_win_pkg::SMP_W,
  parameter int COEF_W = hw_win_pkg::COEF_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic                           bypass_i,
  input  logic                           valid_i,
  input  logic signed [SMP_W-1:0]        smp_i,
  input  logic        [COEF_W-1:0]       coef_i,
  output logic signed [SMP_W+COEF_W-1:0] data_o,
  output logic                           valid_o
);

  localparam int PW = SMP_W + COEF_W;

  logic                    en_prev_q;
  logic signed [SMP_W-1:0] smp_hold_q;
  logic [COEF_W-1:0]       coef_hold_q;
  logic signed [SMP_W-1:0] smp_eff;
  logic [COEF_W-1:0]       coef_eff;
  logic signed [PW-1:0]    smp_ext;
  logic signed [PW-1:0]    coef_ext;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    data_q;
  logic                    valid_q;

  // The memories answer one cycle late, so during a stall the held address
  // already points at the next index. The operands are snapshotted while the
  // previous cycle advanced and used whenever it did not, keeping stage 1
  // aligned with the index it was issued for.
  always_comb begin
    smp_eff  = en_prev_q ? smp_i  : smp_hold_q;
    coef_eff = en_prev_q ? coef_i : coef_hold_q;
    smp_ext  = {{COEF_W{smp_eff[SMP_W-1]}}, smp_eff};
    coef_ext = {{SMP_W{1'b0}}, coef_eff};
    if (bypass_i) begin
      prod = {smp_eff, {COEF_W{1'b0}}};
    end else begin
      // |smp| * (2^COEF_W - 1) always fits in PW signed bits.
      prod = smp_ext * coef_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev_q   <= 1'b1;
      smp_hold_q  <= '0;
      coef_hold_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      en_prev_q <= en_i;
      if (en_prev_q) begin
        smp_hold_q  <= smp_i;
        coef_hold_q <= coef_i;
      end
      if (en_i) begin
        data_q  <= prod;
        valid_q <= valid_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/hw_window_ctrl.sv
// hw_window_ctrl -- frame windowing controller.
// Reads FRAME_LEN samples and window coefficients by index, multiplies them
// and streams the results out under valid/ready flow control.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame request, sampled only in IDLE
//   win_bypass  : (only with HW_WIN_BYPASS_EN) skip coefficient, latched at start
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse after the last beat is accepted
//   smp_addr    : sample buffer address (synchronous read, 1-cycle latency)
//   smp_data    : signed sample for the previous cycle's address
//   rom_addr    : window ROM address (registered ROM, 1-cycle latency)
//   rom_data    : unsigned coefficient for the previous cycle's address
//   win_data    : signed windowed sample
//   win_valid   : win_data valid
//   win_ready   : downstream accept
// Optional feature macro: HW_WIN_BYPASS_EN
module hw_window_ctrl #(
  parameter int FRAME_LEN = hw_win_pkg::FRAME_LEN,
  parameter int SMP_W     = hw_win_pkg::SMP_W,
  parameter int COEF_W    = hw_win_pkg::COEF_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
`ifdef HW_WIN_BYPASS_EN
  input  logic                           win_bypass,
`endif
  output logic                           busy,
  output logic                           done,
  output logic        [6:0]              smp_addr,
  input  logic signed [SMP_W-1:0]        smp_data,
  output logic        [6:0]              rom_addr,
  input  logic        [COEF_W-1:0]       rom_data,
  output logic signed [SMP_W+COEF_W-1:0] win_data,
  output logic                           win_valid,
  input  logic                           win_ready
);

  import hw_win_pkg::*;

  localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic       s1_valid_q, s1_valid_d;
  logic       done_q, done_d;
  logic       win_byp;
  logic       adv;

  assign adv = !win_valid | win_ready;

`ifdef HW_WIN_BYPASS_EN
  logic byp_q, byp_d;

  always_comb begin
    byp_d = byp_q;
    if (state_q == ST_IDLE && start) begin
      byp_d = win_bypass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= byp_d;
    end
  end

  assign win_byp = byp_q;
`else
  assign win_byp = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    s1_valid_d = s1_valid_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          s1_valid_d = 1'b1;
          // The counter parks on the last index instead of wrapping.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          s1_valid_d = 1'b0;
        end
        // Stage 1 empty and the output register holding the last beat.
        if (!s1_valid_q && win_valid && win_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      done_q     <= done_d;
    end
  end

  hw_win_mac #(
    .SMP_W  (SMP_W),
    .COEF_W (COEF_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (adv),
    .bypass_i (win_byp),
    .valid_i  (s1_valid_q),
    .smp_i    (smp_data),
    .coef_i   (rom_data),
    .data_o   (win_data),
    .valid_o  (win_valid)
  );

  assign smp_addr = idx_q;
  assign rom_addr = idx_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: doc/hw_window_ctrl.md
HW_WINDOW_CTRL -- requirements
Module: hw_window_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named clk and rst_n.
REQ-002 Parameter FRAME_LEN SHALL default to 80 and SHALL set the number of samples per frame.
REQ-003 Parameter SMP_W SHALL default to 16 and SHALL set the signed sample width.
REQ-004 Parameter COEF_W SHALL default to 4 and SHALL set the unsigned window coefficient width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  frame request; sampled only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at frame completion.
REQ-010 smp_addr  out  7  sample buffer read address (synchronous read, 1-cycle latency).
REQ-011 smp_data  in  SMP_W  signed sample for the address issued in the previous cycle.
REQ-012 rom_addr  out  7  window ROM address (registered ROM, 1-cycle latency).
REQ-013 rom_data  in  COEF_W  coefficient for the address issued in the previous cycle.
REQ-014 win_data  out  SMP_W+COEF_W  signed windowed sample.
REQ-015 win_valid  out  1  win_data valid.
REQ-016 win_ready  in  1  downstream accept.

Function
REQ-017 The FSM SHALL have three states, IDLE, RUN and DRAIN, with transitions IDLE->RUN on start, RUN->DRAIN after address FRAME_LEN-1 advances, and DRAIN->IDLE on the final handshake.
REQ-018 smp_addr and rom_addr SHALL both equal the 7-bit index counter, which SHALL be cleared to 0 on IDLE->RUN.
REQ-019 Advance SHALL be defined as adv = !win_valid | win_ready.
REQ-020 The counter and all pipeline stages SHALL update only when adv is high; otherwise addresses SHALL be held so the memories re-present identical data.
REQ-021 A stage-1 valid flag SHALL mark that the memory outputs correspond to the index issued in the previous advancing cycle.
REQ-022 The output register SHALL capture smp_data*rom_data (signed x unsigned, full width, no rounding) and win_valid on each adv.
REQ-023 Latency SHALL be 2: with win_ready held high, index 0 SHALL appear on win_data after the second rising edge following the edge that samples start.
REQ-024 With win_ready held high, the output SHALL be exactly FRAME_LEN consecutive valid beats, in index order 0..FRAME_LEN-1.
REQ-025 While win_valid=1 and win_ready=0, win_data SHALL be held stable and no index SHALL be skipped or duplicated.
REQ-026 done SHALL pulse in the cycle after the handshake of index FRAME_LEN-1; busy SHALL fall in the same cycle.
REQ-027 start asserted while busy SHALL be ignored, and start in the same cycle as done SHALL NOT be lost: it is sampled in IDLE on the next cycle.
REQ-028 The counter SHALL NOT wrap past FRAME_LEN-1 within a frame.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, counter=0, stage-1 valid=0, win_valid=0, win_data=0, done=0 and busy=0, including mid-frame.
REQ-030 A frame in progress at reset SHALL be discarded and SHALL NOT be resumed.

Configuration
REQ-031 When the macro HW_WIN_BYPASS_EN is defined, an input win_bypass (1 bit) SHALL exist and SHALL be latched at IDLE->RUN.
REQ-032 When HW_WIN_BYPASS_EN is defined and the latched win_bypass=1, win_data SHALL be smp_data sign-extended and shifted left by COEF_W, with rom_data ignored and timing unchanged.
REQ-033 When HW_WIN_BYPASS_EN is undefined, no win_bypass port SHALL exist and the windowing multiply SHALL always apply.

Structure
REQ-034 Package hw_win_pkg SHALL hold FRAME_LEN, SMP_W, COEF_W, the state enum and the product-width constant.
REQ-035 The multiply and output register SHALL be in sub-module hw_win_mac (enable = adv); the coefficient ROM SHALL remain external.

Verification
REQ-036 Constant smp_data=1000, win_ready=1, one start -> 80 beats; beats 0 and 79 = 1000, beat 20 = 8000, beats 39 and 40 = 15000, then one done pulse.
REQ-037 Same stimulus with win_ready low for 5 cycles at beat 10 -> beat 10 held for 5 cycles, with no gap, skip or duplicate afterward.
REQ-038 smp_data=-32768 at beat 39 -> win_data = -491520 (20-bit).
REQ-039 start pulsed again at beat 30, and start asserted on the done cycle -> the first is ignored; the second frame begins one cycle after done.
REQ-040 rst_n low at beat 50 -> all outputs 0 asynchronously; after release and a new start, the frame restarts at index 0.
REQ-041 With HW_WIN_BYPASS_EN defined and win_bypass=1, smp_data=100 -> all 80 beats = 1600.
